// File: rtl/led_p2s_rx.sv
// Receives the LED shift-chain protocol and rebuilds the frame word on clk.
// Uses a shift-register chain with an idle-timeout frame checker.
module led_p2s_rx #(
    parameter int FRAME_BITS  = 16,
    parameter int IDLE_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                clear,
    input  logic                                led_clk,
    input  logic                                led_d0,
    input  logic                                led_clr,
    input  logic                                led_en,
    output logic [FRAME_BITS-1:0]               led_q,
    output logic                                frame_valid,
    output logic                                frame_err,
    output logic                                busy,
    output logic [$clog2(FRAME_BITS+2)-1:0]     bit_cnt
);

    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam logic [CW-1:0] CNT_FULL  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT   = CW'(FRAME_BITS + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] d_sync;
    logic [SYNC_STAGES-1:0] clr_sync;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   clk_prev;
    logic                   rise;
    logic                   d_smp;
    logic [FRAME_BITS-1:0]  sr;
    logic [IW-1:0]          idle_cnt;
    logic                   clk_s;
    logic                   d_s;
    logic                   clr_s;
    logic                   en_s;
    logic                   accept;

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign d_s   = d_sync[SYNC_STAGES-1];
    assign clr_s = clr_sync[SYNC_STAGES-1];
    assign en_s  = en_sync[SYNC_STAGES-1];

    // Clock sync resets high so leaving reset with led_clk low is never seen as an edge.
    always_ff @(posedge clk) begin
        if (clear) begin
            clk_sync <= '1;
            d_sync   <= '0;
            clr_sync <= '1;
            en_sync  <= '1;
            clk_prev <= 1'b1;
            rise     <= 1'b0;
            d_smp    <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], led_clk};
            d_sync   <= {d_sync[SYNC_STAGES-2:0], led_d0};
            clr_sync <= {clr_sync[SYNC_STAGES-2:0], led_clr};
            en_sync  <= {en_sync[SYNC_STAGES-2:0], led_en};
            clk_prev <= clk_s;
            rise     <= clk_s & ~clk_prev;
            d_smp    <= d_s;
        end
    end

    assign accept = rise & en_s & clr_s;
    assign busy   = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (clear) begin
            state       <= IDLE;
            sr          <= '0;
            led_q       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            bit_cnt     <= '0;
            idle_cnt    <= '0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (!clr_s) begin
                state    <= IDLE;
                sr       <= '0;
                led_q    <= '0;
                bit_cnt  <= '0;
                idle_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            sr       <= {sr[FRAME_BITS-2:0], d_smp};
                            bit_cnt  <= CW'(1);
                            idle_cnt <= '0;
                            state    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (accept) begin
                            sr       <= {sr[FRAME_BITS-2:0], d_smp};
                            idle_cnt <= '0;
                            if (bit_cnt != CNT_SAT) begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            state    <= DONE;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        if (bit_cnt == CNT_FULL) begin
                            led_q       <= sr;
                            frame_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // An edge landing here is bit 1 of the next frame.
                        if (accept) begin
                            sr       <= {sr[FRAME_BITS-2:0], d_smp};
                            bit_cnt  <= CW'(1);
                            idle_cnt <= '0;
                            state    <= SHIFT;
                        end else begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/led_p2s_rx.md
# led_p2s_rx

Serial-to-parallel receiver for the LED shift-chain protocol: it listens on `led_clk` / `led_d0` / `led_clr` / `led_en` and reconstructs the 16-bit LED word that a P2S LED driver shifts out. The receiver behaves like the board's shift-register chain plus a frame checker. It sits on the receive side of an FPGA-to-FPGA LED link and in loopback benches against the LED driver, running on its own `clk`, which is faster than `led_clk`.

## Interface
- `FRAME_BITS`, 16: bits per frame; also the width of `led_q`.
- `IDLE_CYCLES`, 64: `clk` cycles without a `led_clk` rising edge that end a frame.
- `SYNC_STAGES`, 2: synchronizer depth on `led_clk`, `led_d0`, `led_clr` and `led_en`; minimum 2.
- `clk`  in  1: system clock; all state updates on its rising edge.
- `clear`  in  1: synchronous, active-high reset.
- `led_clk`  in  1: serial shift clock, asynchronous to `clk`; idles high; data is taken on its rising edge.
- `led_d0`  in  1: serial data, valid at the `led_clk` rising edge.
- `led_clr`  in  1: active-low chain clear, asynchronous, level-sensitive.
- `led_en`  in  1: chain enable; while low, `led_clk` edges are ignored.
- `led_q`  out  FRAME_BITS: last accepted frame.
- `frame_valid`  out  1: one-cycle pulse; `led_q` was updated in the same cycle.
- `frame_err`  out  1: one-cycle pulse; the frame ended with a bit count other than `FRAME_BITS`.
- `busy`  out  1: a frame is in progress (state SHIFT).
- `bit_cnt`  out  clog2(FRAME_BITS+2): bits received in the current frame, saturating at `FRAME_BITS+1`.

## Operation
- **Synchronizers.**
  - Each input passes through `SYNC_STAGES` flops.
  - `led_clk` and `led_en` synchronizer flops reset to 1; `led_clr` flops reset to 1; `led_d0` flops reset to 0.
  - A rising-edge detector uses one extra flop on synchronized `led_clk`. That flop resets to 1, so no edge is seen out of reset.
  - `led_d0` gets one matching extra flop, so the data sampled at the edge is the value that was present at that `led_clk` edge.
- **Shift register.**
  - `sr` has `FRAME_BITS` bits.
  - On an accepted edge: `sr <= {sr[FRAME_BITS-2:0], d}`.
  - The first bit of a frame ends up in `led_q[FRAME_BITS-1]`; the last bit in `led_q[0]`.
- **FSM states: IDLE, SHIFT, DONE.**
  - IDLE: an accepted edge shifts, sets `bit_cnt` to 1, clears the idle counter, and moves to SHIFT.
  - SHIFT:
    - An accepted edge shifts, increments `bit_cnt` (saturating), and clears the idle counter.
    - With no edge, the idle counter increments.
    - When the idle counter reaches `IDLE_CYCLES-1`, go to DONE.
  - DONE lasts one cycle, then returns to IDLE with `bit_cnt` set to 0.
    - If `bit_cnt == FRAME_BITS`: `led_q <= sr`, pulse `frame_valid`.
    - Otherwise: pulse `frame_err` and leave `led_q` unchanged.
    - An edge arriving in DONE is accepted as bit 1 of a new frame; the next state is SHIFT instead of IDLE.
- **Accepted edge.** A detected rising edge while synchronized `led_en` = 1 and synchronized `led_clr` = 1.
- **Chain clear.** Synchronized `led_clr` = 0 has priority over everything except `clear`.
  - Sets `sr`, `led_q`, `bit_cnt` and the idle counter to 0.
  - Forces state to IDLE.
  - No `frame_valid` or `frame_err` pulse.
  - Edges are ignored while it is held.
- **`led_en` low.** Edges are ignored, but the idle counter keeps running. A frame therefore still times out.
- **Overflow.**
  - More than `FRAME_BITS` edges: `sr` keeps the last `FRAME_BITS` bits.
  - `bit_cnt` saturates at `FRAME_BITS+1`.
  - At timeout this gives `frame_err`, and `led_q` is not updated.
- **Counter width.** The idle counter is clog2(`IDLE_CYCLES`) bits.

## Timing
- **Reset.** `clear` = 1 at a `clk` edge gives, on the next cycle:
  - `led_q` = 0, `frame_valid` = 0, `frame_err` = 0, `busy` = 0, `bit_cnt` = 0;
  - state IDLE; all synchronizers at their reset values.
  - Reset mid-frame discards the frame silently.
- **Input rate limits.**
  - `led_clk` high time ≥ `SYNC_STAGES+1` `clk` periods.
  - `led_clk` low time ≥ `SYNC_STAGES+1` `clk` periods.
  - `led_d0` is stable for `SYNC_STAGES+1` `clk` periods around each rising edge.
  - `IDLE_CYCLES` > 2 × the `led_clk` period in `clk` cycles.
- **Edge-to-shift latency.** `SYNC_STAGES+1` `clk` cycles after the `led_clk` rise is captured by the first flop.
- **Frame end.** `frame_valid` / `frame_err` rises exactly `IDLE_CYCLES+1` cycles after the cycle in which the last bit was shifted, and lasts 1 cycle.
- **`busy`.** High from the cycle after the first shift through the last SHIFT cycle; low in DONE.
- **`led_q`.** Changes only in the `frame_valid` cycle or on a chain clear/reset.

## Test plan
- **Reset.** Hold `clear` for 3 cycles with `led_clk` = 0 → all outputs 0. Release `clear` with `led_clk` still low, then raise `led_clk` → exactly one edge is accepted and `bit_cnt` = 1.
- **Normal frame.**
  - Stimulus: a 16-bit frame 0xA5C3, MSB first, `led_clk` period 8 `clk` cycles.
  - Response: `bit_cnt` reaches 16, then `IDLE_CYCLES+1` cycles later `frame_valid` = 1 for 1 cycle with `led_q` = 0xA5C3, and `frame_err` = 0.
- **Short and long frames.**
  - 15 bits → `frame_err` pulse, `led_q` keeps its previous value (0xA5C3).
  - 18 bits → `frame_err`, `bit_cnt` saturated at 17, `led_q` unchanged.
- **Chain clear.** Assert `led_clr` = 0 after 9 bits of a frame → within `SYNC_STAGES+1` cycles `led_q` = 0, `bit_cnt` = 0, `busy` = 0, no pulses. After release, a full frame 0x0001 → `frame_valid`, `led_q` = 0x0001.
- **Enable gating.** Drive 16 edges with `led_en` = 0 for edges 5–8 → 12 accepted, `frame_err` at timeout. With `led_en` = 1 throughout → `frame_valid`.
- **Back-to-back frames.** Frame 0x1234, then the first edge of frame 0xFFFF lands in the DONE cycle → `frame_valid` with 0x1234, the new frame continues without loss, and the second `frame_valid` gives `led_q` = 0xFFFF.
